piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer; next generation of the fixed 8-bit encoder.
- Generalises word width and bit order, and adds a valid/ready input handshake, a bit-rate enable, framing strobes and a defined idle line level.
- Sits between a byte/word producer and the serial line driver.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range WIDTH >= 2.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first.
- IDLE_LEVEL, 0, value driven on serial_out when no frame is active.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_data, input, WIDTH, parallel word to transmit.
- in_valid, input, 1, producer has a word on in_data.
- in_ready, output, 1, block accepts in_data this cycle (combinational).
- bit_tick, input, 1, advance one bit on this edge; tie to 1 for one bit per clock.
- serial_out, output, 1, registered serial data.
- serial_valid, output, 1, registered; serial_out carries a data bit.
- frame_start, output, 1, registered; high while the first bit of a word is on serial_out.
- word_done, output, 1, registered one-cycle pulse when the last bit of a word retires.

Behaviour:
- Reset (synchronous, on the edge where reset=1) overrides everything:
  - state=IDLE; shift register=0; bit counter=0.
  - serial_out=IDLE_LEVEL; serial_valid=0; frame_start=0; word_done=0.
  - Reset mid-frame aborts the frame: no word_done, remaining bits discarded.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready = (count==WIDTH-1) & bit_tick.
- Handshake: a word is accepted on an edge where in_valid & in_ready. in_data is sampled only on that edge; the producer may change it afterwards.
- Accept edge:
  - Shift register loads in_data; count=0; state=SHIFT.
  - serial_out = first bit (in_data[0] if LSB_FIRST, else in_data[WIDTH-1]).
  - serial_valid=1; frame_start=1.
  - Latency: first bit visible in the cycle after acceptance. bit_tick is not required on the accept edge.
- In SHIFT, on an edge with bit_tick=1 and count<WIDTH-1:
  - count+1; next bit presented; frame_start=0.
  - Shift direction follows LSB_FIRST; the vacated bit is filled with 0.
- With bit_tick=0: serial_out, count and all strobes hold. Each bit therefore lasts from one bit_tick edge to the next.
- On an edge with bit_tick=1 and count==WIDTH-1, the last bit retires:
  - word_done=1 for exactly one cycle.
  - If in_valid=1: new word accepted per the accept-edge rule, with no gap, and frame_start re-asserts.
  - Else: state=IDLE; serial_out=IDLE_LEVEL; serial_valid=0.
- word_done is 0 on every other edge.
- A word occupies exactly WIDTH bit periods; the first period begins at the accept edge.
- Counter width is clog2(WIDTH), with a minimum of 1 bit. The counter never exceeds WIDTH-1 and has no wrap-around beyond that value.
- in_valid in SHIFT before the last tick is ignored; the producer holds it until the handshake.
- Simultaneous reset and in_valid: reset wins and nothing is accepted.

Decomposition:
- Shared package holds:
  - State enum (ST_IDLE, ST_SHIFT).
  - clog2 helper function.
  - Default width constant WORD_W=8 for the encoder family.
- One natural sub-module: bit_counter (synchronous reset, increment enable, terminal-count flag at WIDTH-1), reusable by the matching deserializer.
- The shift register and FSM stay in piso_serializer.

Test Plan:
- Basic LSB-first: WIDTH=8, LSB_FIRST=1, bit_tick=1, send 0xA5 → serial_out 1,0,1,0,0,1,0,1 over 8 cycles. frame_start on bit 1 only; word_done on the 8th tick; then serial_out=0, serial_valid=0.
- MSB-first: LSB_FIRST=0, send 0xA5 → 1,0,1,0,0,1,0,1. Send 0x01 → seven 0s then 1.
- Back-to-back: in_valid held with 0x0F then 0xF0 → 16 consecutive valid bits, no idle cycle. in_ready high only on the 8th tick; frame_start pulses at bits 1 and 9.
- Rate enable: bit_tick high every 4th cycle, send 0x3C → each bit held exactly 4 cycles; word_done one cycle wide.
- Reset mid-frame: reset asserted after the 3rd bit → next cycle serial_out=IDLE_LEVEL, serial_valid=0, in_ready=1, no word_done. A new word 0x81 then serializes correctly from bit 1.
- Width/idle generality: WIDTH=12, IDLE_LEVEL=1, send 0xABC → 12 bits in LSB order; line reads 1 before and after the frame.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the serial encoder family.
// Used by the serializer and its bit counter, and available to a matching deserializer.
package piso_serializer_pkg;

    localparam int WORD_W = 8;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Ceiling log2. Callers needing a 1-bit minimum apply it themselves.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Saturating bit-position counter with a terminal flag at WIDTH-1.
// Clear takes priority over enable.
module piso_serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = WORD_W
)
(
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    // Stops at LAST so the count never wraps past the final bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input, bit-rate enable,
// framing strobes and a defined idle line level.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = WORD_W,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_tick,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             word_done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic             r_serialOut;
    logic             r_serialValid;
    logic             r_frameStart;
    logic             r_wordDone;

    logic [WIDTH-1:0] w_shifted;
    logic             w_firstBit;
    logic             w_nextBit;
    logic             w_terminal;
    logic             w_lastTick;
    logic             w_accept;

    // The ready window in SHIFT is the edge that retires the final bit.
    assign w_lastTick = (r_state == ST_SHIFT) && bit_tick && w_terminal;
    assign in_ready   = (r_state == ST_IDLE) || w_lastTick;
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_shifted  = r_shift;
        w_firstBit = in_data[0];
        w_nextBit  = r_shift[0];
        if (LSB_FIRST) begin
            w_shifted  = r_shift >> 1;
            w_firstBit = in_data[0];
            w_nextBit  = w_shifted[0];
        end else begin
            w_shifted  = r_shift << 1;
            w_firstBit = in_data[WIDTH-1];
            w_nextBit  = w_shifted[WIDTH-1];
        end
    end

    piso_serializer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bitCounter (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_accept || w_lastTick),
        .i_enable   ((r_state == ST_SHIFT) && bit_tick),
        .o_terminal (w_terminal)
    );

    // Without a tick, line and strobes hold; word_done is a pulse only.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_serialOut   <= IDLE_LEVEL;
            r_serialValid <= 1'b0;
            r_frameStart  <= 1'b0;
            r_wordDone    <= 1'b0;
        end else begin
            r_wordDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state       <= ST_SHIFT;
                        r_shift       <= in_data;
                        r_serialOut   <= w_firstBit;
                        r_serialValid <= 1'b1;
                        r_frameStart  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_tick) begin
                        if (w_terminal) begin
                            r_wordDone <= 1'b1;
                            if (in_valid) begin
                                r_shift       <= in_data;
                                r_serialOut   <= w_firstBit;
                                r_serialValid <= 1'b1;
                                r_frameStart  <= 1'b1;
                            end else begin
                                r_state       <= ST_IDLE;
                                r_shift       <= '0;
                                r_serialOut   <= IDLE_LEVEL;
                                r_serialValid <= 1'b0;
                                r_frameStart  <= 1'b0;
                            end
                        end else begin
                            r_shift      <= w_shifted;
                            r_serialOut  <= w_nextBit;
                            r_frameStart <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign serial_out   = r_serialOut;
    assign serial_valid = r_serialValid;
    assign frame_start  = r_frameStart;
    assign word_done    = r_wordDone;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances cover LSB-first 8-bit,
// MSB-first 8-bit, and 12-bit with a high idle line.
module tb_piso_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        bitTick;
    logic [2:0]  inValid;
    logic [7:0]  inData0;
    logic [7:0]  inData1;
    logic [11:0] inData2;
    logic [2:0]  inReady;
    logic [2:0]  serialOut;
    logic [2:0]  serialValid;
    logic [2:0]  frameStart;
    logic [2:0]  wordDone;

    int assertCount = 0;
    int failCount   = 0;
    logic expQ[$];

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (
        .clock(clock), .reset(reset), .in_data(inData0), .in_valid(inValid[0]),
        .in_ready(inReady[0]), .bit_tick(bitTick), .serial_out(serialOut[0]),
        .serial_valid(serialValid[0]), .frame_start(frameStart[0]), .word_done(wordDone[0])
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
        .clock(clock), .reset(reset), .in_data(inData1), .in_valid(inValid[1]),
        .in_ready(inReady[1]), .bit_tick(bitTick), .serial_out(serialOut[1]),
        .serial_valid(serialValid[1]), .frame_start(frameStart[1]), .word_done(wordDone[1])
    );

    piso_serializer #(.WIDTH(12), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u2 (
        .clock(clock), .reset(reset), .in_data(inData2), .in_valid(inValid[2]),
        .in_ready(inReady[2]), .bit_tick(bitTick), .serial_out(serialOut[2]),
        .serial_valid(serialValid[2]), .frame_start(frameStart[2]), .word_done(wordDone[2])
    );

    function automatic int widthOf(input int sel);
        return (sel == 2) ? 12 : 8;
    endfunction

    function automatic logic idleOf(input int sel);
        return (sel == 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic nextEdge();
        @(posedge clock);
        #1;
    endtask

    // Expected line bits for one word, in transmission order.
    task automatic pushWord(input int sel, input logic [11:0] data);
        int w;
        w = widthOf(sel);
        for (int i = 0; i < w; i++) begin
            if (sel == 1) expQ.push_back(data[w-1-i]);
            else          expQ.push_back(data[i]);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic valid, input logic [11:0] data);
        inValid = 3'b000;
        inValid[sel] = valid;
        inData0 = 8'h00;
        inData1 = 8'h00;
        inData2 = 12'h000;
        case (sel)
            0: inData0 = data[7:0];
            1: inData1 = data[7:0];
            default: inData2 = data;
        endcase
    endtask

    task automatic popExpected(output logic bitOut);
        if (expQ.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_underflow observed=empty expected=pending_bit");
            bitOut = 1'b0;
        end else begin
            bitOut = expQ.pop_front();
        end
    endtask

    task automatic checkIdle(input int sel, input logic doneExp);
        checkOutput("idle_serial_out", serialOut[sel], idleOf(sel));
        checkOutput("idle_serial_valid", serialValid[sel], 1'b0);
        checkOutput("idle_frame_start", frameStart[sel], 1'b0);
        checkOutput("idle_word_done", wordDone[sel], doneExp);
        checkOutput("idle_in_ready", inReady[sel], 1'b1);
    endtask

    task automatic startWord(input int sel, input logic [11:0] data);
        applyStimulus(sel, 1'b1, data);
        #1;
        checkOutput("accept_in_ready", inReady[sel], 1'b1);
        pushWord(sel, data);
        nextEdge();
        applyStimulus(sel, 1'b0, 12'h000);
    endtask

    // Walks one accepted word; optionally holds the next word valid for a gapless chain.
    task automatic runFrame(input int sel, input int period, input logic prevDone,
                            input logic nextValid, input logic [11:0] nextData);
        int   w;
        logic expBit;
        w = widthOf(sel);
        applyStimulus(sel, nextValid, nextData);
        for (int i = 0; i < w; i++) begin
            popExpected(expBit);
            for (int c = 0; c < period; c++) begin
                checkOutput("serial_out", serialOut[sel], expBit);
                checkOutput("serial_valid", serialValid[sel], 1'b1);
                checkOutput("frame_start", frameStart[sel], (i == 0));
                checkOutput("word_done", wordDone[sel], ((i == 0) && (c == 0)) ? prevDone : 1'b0);
                bitTick = (c == period - 1);
                #1;
                checkOutput("in_ready", inReady[sel], (i == w - 1) && bitTick);
                if ((i == w - 1) && bitTick && nextValid) pushWord(sel, nextData);
                nextEdge();
            end
        end
        applyStimulus(sel, 1'b0, 12'h000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expBit;
        reset   = 1'b1;
        bitTick = 1'b1;
        applyStimulus(0, 1'b1, 12'h0A5);
        nextEdge();
        nextEdge();
        applyStimulus(0, 1'b0, 12'h000);
        for (int s = 0; s < 3; s++) checkIdle(s, 1'b0);
        reset = 1'b0;
        nextEdge();

        $display("[TB] LSB-first 0xA5");
        startWord(0, 12'h0A5);
        runFrame(0, 1, 1'b0, 1'b0, 12'h000);
        checkIdle(0, 1'b1);
        nextEdge();
        checkIdle(0, 1'b0);

        $display("[TB] MSB-first 0xA5 and 0x01");
        startWord(1, 12'h0A5);
        runFrame(1, 1, 1'b0, 1'b0, 12'h000);
        checkIdle(1, 1'b1);
        nextEdge();
        startWord(1, 12'h001);
        runFrame(1, 1, 1'b0, 1'b0, 12'h000);
        checkIdle(1, 1'b1);
        nextEdge();
        checkIdle(1, 1'b0);

        $display("[TB] back-to-back 0x0F then 0xF0");
        startWord(0, 12'h00F);
        runFrame(0, 1, 1'b0, 1'b1, 12'h0F0);
        runFrame(0, 1, 1'b1, 1'b0, 12'h000);
        checkIdle(0, 1'b1);
        nextEdge();
        checkIdle(0, 1'b0);

        $display("[TB] rate enable every 4th cycle, 0x3C");
        bitTick = 1'b0;
        startWord(0, 12'h03C);
        runFrame(0, 4, 1'b0, 1'b0, 12'h000);
        checkIdle(0, 1'b1);
        bitTick = 1'b0;
        nextEdge();
        checkIdle(0, 1'b0);

        $display("[TB] reset mid-frame then 0x81");
        bitTick = 1'b1;
        startWord(0, 12'h05A);
        for (int i = 0; i < 3; i++) begin
            popExpected(expBit);
            checkOutput("pre_reset_serial_out", serialOut[0], expBit);
            checkOutput("pre_reset_frame_start", frameStart[0], (i == 0));
            if (i < 2) nextEdge();
        end
        reset = 1'b1;
        nextEdge();
        reset = 1'b0;
        checkIdle(0, 1'b0);
        expQ.delete();
        nextEdge();
        checkIdle(0, 1'b0);
        startWord(0, 12'h081);
        runFrame(0, 1, 1'b0, 1'b0, 12'h000);
        checkIdle(0, 1'b1);
        nextEdge();

        $display("[TB] WIDTH=12 idle-high 0xABC");
        checkIdle(2, 1'b0);
        startWord(2, 12'hABC);
        runFrame(2, 1, 1'b0, 1'b0, 12'h000);
        checkIdle(2, 1'b1);
        nextEdge();
        checkIdle(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
